// File: rtl/cnn_fmap_window_gen.sv
// Sliding-window generator for a CNN feature map: turns a raster pixel stream into
// KY x KX x CI windows (stride 1, no padding), one registered window per completing pixel.
module cnn_fmap_window_gen #(
    parameter int CI     = 3,
    parameter int KX     = 3,
    parameter int KY     = 3,
    parameter int I_F_BW = 8,
    parameter int IX     = 8,
    parameter int IY     = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          i_soft_reset,
    input  logic                          i_in_valid,
    input  logic [CI*I_F_BW-1:0]          i_in_pixel,
    output logic                          o_ot_valid,
    output logic [CI*KX*KY*I_F_BW-1:0]    o_ot_fmap,
    output logic                          o_frame_done
);

    localparam int PW = CI * I_F_BW;
    localparam int FW = CI * KX * KY * I_F_BW;
    localparam int CW = (IX > 1) ? $clog2(IX) : 1;
    localparam int RW = (IY > 1) ? $clog2(IY) : 1;

    logic          accept;
    logic          col_last;
    logic          row_last;
    logic          win_ready;
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // line_buf[0] holds the previous row, line_buf[KY-2] the oldest one still needed.
    logic [PW-1:0] line_buf [KY-1][IX];
    logic [PW-1:0] win      [KY][KX];
    logic [PW-1:0] win_next [KY][KX];
    logic [FW-1:0] fmap_next;

    always_comb begin
        accept    = i_in_valid & ~i_soft_reset;
        col_last  = (col == CW'(IX - 1));
        row_last  = (row == RW'(IY - 1));
        win_ready = (row >= RW'(KY - 1)) && (col >= CW'(KX - 1));
    end

    // Next window: shift every row one column left and append the new column on the right.
    always_comb begin
        for (int ky = 0; ky < KY; ky++) begin
            for (int kx = 0; kx < KX - 1; kx++) begin
                win_next[ky][kx] = win[ky][kx+1];
            end
        end
        for (int ky = 0; ky < KY - 1; ky++) begin
            win_next[ky][KX-1] = line_buf[KY-2-ky][col];
        end
        win_next[KY-1][KX-1] = i_in_pixel;
    end

    always_comb begin
        fmap_next = '0;
        for (int c = 0; c < CI; c++) begin
            for (int ky = 0; ky < KY; ky++) begin
                for (int kx = 0; kx < KX; kx++) begin
                    fmap_next[(c*KX*KY + ky*KX + kx)*I_F_BW +: I_F_BW] =
                        win_next[ky][kx][c*I_F_BW +: I_F_BW];
                end
            end
        end
    end

    // NOTE: pixel storage has no reset; stale contents are never emitted because the
    // row/col gating only opens once the current frame has refilled every tap.
    always_ff @(posedge clk) begin
        if (accept) begin
            win            <= win_next;
            line_buf[0][col] <= i_in_pixel;
            for (int k = 1; k < KY - 1; k++) begin
                line_buf[k][col] <= line_buf[k-1][col];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col          <= '0;
            row          <= '0;
            o_ot_valid   <= 1'b0;
            o_frame_done <= 1'b0;
            o_ot_fmap    <= '0;
        end else if (i_soft_reset) begin
            col          <= '0;
            row          <= '0;
            o_ot_valid   <= 1'b0;
            o_frame_done <= 1'b0;
            o_ot_fmap    <= '0;
        end else begin
            o_ot_valid   <= 1'b0;
            o_frame_done <= 1'b0;
            if (i_in_valid) begin
                col <= col_last ? '0 : col + 1'b1;
                if (col_last) begin
                    row <= row_last ? '0 : row + 1'b1;
                end
                if (win_ready) begin
                    o_ot_valid   <= 1'b1;
                    o_ot_fmap    <= fmap_next;
                    o_frame_done <= row_last & col_last;
                end
            end
        end
    end

endmodule

// File: doc/cnn_fmap_window_gen.md
CNN_FMAP_WINDOW_GEN -- requirements
Module: cnn_fmap_window_gen

Interface
REQ-001 SHALL have parameter CI, default 3, number of input channels per pixel.
REQ-002 SHALL have parameter KX, default 3, kernel width in pixels.
REQ-003 SHALL have parameter KY, default 3, kernel height in rows.
REQ-004 SHALL have parameter I_F_BW, default 8, bits per feature-map element.
REQ-005 SHALL have parameter IX, default 8, image width in pixels (IX >= KX).
REQ-006 SHALL have parameter IY, default 8, image height in rows (IY >= KY).
REQ-007 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-008 SHALL have port reset_n, input, 1, reset, asynchronous, active-low.
REQ-009 SHALL have port i_soft_reset, input, 1, synchronous clear, priority over all other inputs.
REQ-010 SHALL have port i_in_valid, input, 1, pixel strobe; no backpressure, a pixel is accepted every cycle it is high.
REQ-011 SHALL have port i_in_pixel, input, CI*I_F_BW, one pixel; channel c at bits [c*I_F_BW +: I_F_BW].
REQ-012 SHALL have port o_ot_valid, output, 1, one-cycle pulse marking a complete window on o_ot_fmap.
REQ-013 SHALL have port o_ot_fmap, output, CI*KX*KY*I_F_BW, window bundle in the packing of REQ-019, ready for the channel-accumulator's fmap input.
REQ-014 SHALL have port o_frame_done, output, 1, one-cycle pulse with the last window of a frame.

Function
REQ-015 SHALL accept pixels in raster order: column counter col 0..IX-1, row counter row 0..IY-1, both advanced only on accepted pixels.
REQ-016 SHALL wrap col to 0 after IX-1 and advance row; after pixel (IY-1, IX-1) SHALL wrap row and col to 0, starting a new frame with no idle cycle.
REQ-017 SHALL hold KY-1 line buffers of IX pixels (all CI channels) plus a KY x KX shift window, updated only on accepted pixels.
REQ-018 SHALL emit a window for an accepted pixel at (row, col) iff row >= KY-1 and col >= KX-1 (stride 1, no padding); (IX-KX+1)*(IY-KY+1) windows per frame.
REQ-019 Window packing: channel c at [c*KX*KY*I_F_BW +: KX*KY*I_F_BW]; element (ky, kx) of that channel at offset (ky*KX+kx)*I_F_BW; ky=0 topmost (oldest) row, kx=0 leftmost (oldest) column.
REQ-020 Element (ky, kx) of a window emitted for pixel (row, col) SHALL equal pixel (row-KY+1+ky, col-KX+1+kx) of the current frame.
REQ-021 Latency: o_ot_valid and o_ot_fmap SHALL be registered, asserted exactly 1 cycle after the accepting edge of the completing pixel.
REQ-022 o_ot_fmap SHALL hold its last value while o_ot_valid is low.
REQ-023 o_ot_valid SHALL be low in any cycle following a cycle with i_in_valid low; gaps in i_in_valid SHALL not change window contents.
REQ-024 o_frame_done SHALL assert in the same cycle as o_ot_valid for the window of pixel (IY-1, IX-1), otherwise low.
REQ-025 Windows SHALL never mix pixels across row boundaries or across frames (guaranteed by REQ-018 column condition).

Reset
REQ-026 On reset_n low, SHALL immediately clear col, row, o_ot_valid, o_frame_done to 0 and o_ot_fmap to 0.
REQ-027 On i_soft_reset high at a clock edge, SHALL perform the same clear as REQ-026, ignoring i_in_valid that cycle.
REQ-028 Line-buffer contents need not be cleared by either reset; after reset the next accepted pixel SHALL be treated as (0,0) of a new frame.

Verification (CI=3, KX=KY=3, I_F_BW=8, IX=IY=8; channel c value = (row*8+col + 64*c) mod 256)
REQ-029 Continuous frame, i_in_valid always high -> exactly 36 o_ot_valid pulses; first 1 cycle after pixel (2,2), ch0 elements 0..8 = {0,1,2,8,9,10,16,17,18}, ch2 element0 = 128.
REQ-030 Same frame with i_in_valid toggling 1,0,1,0 -> identical 36 windows in same order, each 1 cycle after its completing pixel, never two consecutive valid cycles.
REQ-031 Last window -> ch0 = {45,46,47,53,54,55,61,62,63}, o_frame_done high with it, no other o_frame_done pulses.
REQ-032 Two frames back-to-back -> second frame's first window 1 cycle after its 19th pixel, contents per REQ-029; no window between frames mixing data.
REQ-033 i_soft_reset asserted after pixel (4,3) -> o_ot_valid low next cycle; restart frame from pixel 0 -> first window again after 19th pixel with values per REQ-029.
REQ-034 reset_n pulsed low mid-window-emission -> o_ot_valid, o_frame_done, o_ot_fmap zero immediately without clock; post-release behaviour as REQ-033.
